// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: opcode encodings, default widths
// and the skid-buffer state encoding.
package alu_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_OPW   = 3;
    localparam int DEF_CNTW  = 16;

    localparam logic [DEF_OPW-1:0] OP_AND = 3'd0;
    localparam logic [DEF_OPW-1:0] OP_OR  = 3'd1;
    localparam logic [DEF_OPW-1:0] OP_XOR = 3'd2;
    localparam logic [DEF_OPW-1:0] OP_ADD = 3'd3;
    localparam logic [DEF_OPW-1:0] OP_SUB = 3'd4;
    localparam logic [DEF_OPW-1:0] OP_NOT = 3'd5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU datapath, the result stage and its consumer.
// The slave modport is the stage's view; master is the surrounding logic's view.
interface alu_result_stage_if
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPW   = DEF_OPW,
    parameter int CNTW  = DEF_CNTW
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic [OPW-1:0]   in_op;
    logic             in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [OPW-1:0]   out_op;
    logic             out_zero;
    logic             out_neg;
    logic             out_carry;
    logic [CNTW-1:0]  res_count;

    modport slave (
        input  in_valid, in_result, in_op, in_carry, out_ready,
        output in_ready, out_valid, out_result, out_op,
        output out_zero, out_neg, out_carry, res_count
    );

    modport master (
        output in_valid, in_result, in_op, in_carry, out_ready,
        input  in_ready, out_valid, out_result, out_op,
        input  out_zero, out_neg, out_carry, res_count
    );
endinterface

// File: rtl/alu_flag_gen.sv
// Combinational zero/negative/carry flags for one ALU result. Carry is only
// meaningful for the adder path, so it is masked for every other opcode.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPW   = DEF_OPW
) (
    input  logic [WIDTH-1:0] result,
    input  logic [OPW-1:0]   op,
    input  logic             carry_in,
    output logic             zero,
    output logic             neg,
    output logic             carry
);

    // Flag derivation from the captured result and opcode
    always_comb begin
        zero  = 1'b0;
        neg   = 1'b0;
        carry = 1'b0;
        if (result == {WIDTH{1'b0}}) begin
            zero = 1'b1;
        end else begin
            zero = 1'b0;
        end
        neg = result[WIDTH-1];
        case (op)
            OPW'(OP_ADD): carry = carry_in;
            OPW'(OP_SUB): carry = carry_in;
            default:      carry = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the ALU: 2-entry skid buffer (main + skid) with
// a registered in_ready, per-entry flags, and a count of accepted results.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPW   = DEF_OPW,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_result_stage_if.slave bus
);

    stage_state_t     state_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [WIDTH-1:0] main_result_r;
    logic [OPW-1:0]   main_op_r;
    logic             main_zero_r;
    logic             main_neg_r;
    logic             main_carry_r;

    logic [WIDTH-1:0] skid_result_r;
    logic [OPW-1:0]   skid_op_r;
    logic             skid_zero_r;
    logic             skid_neg_r;
    logic             skid_carry_r;

    logic [CNTW-1:0]  res_count_r;

    logic             zero_s;
    logic             neg_s;
    logic             carry_s;
    logic             push_s;
    logic             pop_s;

    alu_flag_gen #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_flag_gen (
        .result   (bus.in_result),
        .op       (bus.in_op),
        .carry_in (bus.in_carry),
        .zero     (zero_s),
        .neg      (neg_s),
        .carry    (carry_s)
    );

    assign push_s = bus.in_valid & in_ready_r;
    assign pop_s  = out_valid_r & bus.out_ready;

    // Skid-buffer FSM: main register drives the outputs, skid absorbs one extra push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= EMPTY;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            main_result_r <= {WIDTH{1'b0}};
            main_op_r     <= {OPW{1'b0}};
            main_zero_r   <= 1'b0;
            main_neg_r    <= 1'b0;
            main_carry_r  <= 1'b0;
            skid_result_r <= {WIDTH{1'b0}};
            skid_op_r     <= {OPW{1'b0}};
            skid_zero_r   <= 1'b0;
            skid_neg_r    <= 1'b0;
            skid_carry_r  <= 1'b0;
            res_count_r   <= {CNTW{1'b0}};
        end else begin
            if (push_s) begin
                res_count_r <= res_count_r + CNTW'(1);
            end else begin
                res_count_r <= res_count_r;
            end
            case (state_r)
                EMPTY: begin
                    if (push_s) begin
                        main_result_r <= bus.in_result;
                        main_op_r     <= bus.in_op;
                        main_zero_r   <= zero_s;
                        main_neg_r    <= neg_s;
                        main_carry_r  <= carry_s;
                        out_valid_r   <= 1'b1;
                        state_r       <= ONE;
                    end else begin
                        state_r <= EMPTY;
                    end
                end
                ONE: begin
                    case ({push_s, pop_s})
                        2'b10: begin
                            skid_result_r <= bus.in_result;
                            skid_op_r     <= bus.in_op;
                            skid_zero_r   <= zero_s;
                            skid_neg_r    <= neg_s;
                            skid_carry_r  <= carry_s;
                            in_ready_r    <= 1'b0;
                            state_r       <= FULL;
                        end
                        2'b01: begin
                            out_valid_r <= 1'b0;
                            state_r     <= EMPTY;
                        end
                        2'b11: begin
                            main_result_r <= bus.in_result;
                            main_op_r     <= bus.in_op;
                            main_zero_r   <= zero_s;
                            main_neg_r    <= neg_s;
                            main_carry_r  <= carry_s;
                            state_r       <= ONE;
                        end
                        default: begin
                            state_r <= ONE;
                        end
                    endcase
                end
                FULL: begin
                    if (pop_s) begin
                        main_result_r <= skid_result_r;
                        main_op_r     <= skid_op_r;
                        main_zero_r   <= skid_zero_r;
                        main_neg_r    <= skid_neg_r;
                        main_carry_r  <= skid_carry_r;
                        in_ready_r    <= 1'b1;
                        state_r       <= ONE;
                    end else begin
                        state_r <= FULL;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty stage
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= EMPTY;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_result = main_result_r;
    assign bus.out_op     = main_op_r;
    assign bus.out_zero   = main_zero_r;
    assign bus.out_neg    = main_neg_r;
    assign bus.out_carry  = main_carry_r;
    assign bus.res_count  = res_count_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: reset, flags, backpressure, streaming,
// counter wrap and asynchronous reset while full.
module tb_alu_result_stage;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_result_stage_if bus ();

    alu_result_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [2:0] op, input logic c);
        bus.in_valid  = 1'b1;
        bus.in_result = d;
        bus.in_op     = op;
        bus.in_carry  = c;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_result = 32'hDEAD_BEEF;
        bus.in_op     = OP_ADD;
        bus.in_carry  = 1'b1;
        bus.out_ready = 1'b0;

        // Reset held with in_valid high: nothing may be accepted
        repeat (3) tick();
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst_count", {48'd0, bus.res_count}, 64'd0);
        check("rst_out_result", {32'd0, bus.out_result}, 64'd0);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        tick();
        check("post_rst_count", {48'd0, bus.res_count}, 64'd0);

        // First push and flags, consumer always ready
        bus.out_ready = 1'b1;
        push(32'h0000_00FF, OP_AND, 1'b0);
        check("first_valid", {63'd0, bus.out_valid}, 64'd1);
        check("first_result", {32'd0, bus.out_result}, 64'h0000_00FF);
        check("first_zero", {63'd0, bus.out_zero}, 64'd0);
        check("first_neg", {63'd0, bus.out_neg}, 64'd0);
        check("first_op", {61'd0, bus.out_op}, 64'd0);
        check("first_count", {48'd0, bus.res_count}, 64'd1);
        push(32'h0000_0000, OP_AND, 1'b0);
        check("zero_flag", {63'd0, bus.out_zero}, 64'd1);
        push(32'h8000_0001, OP_OR, 1'b0);
        check("neg_flag", {63'd0, bus.out_neg}, 64'd1);
        check("neg_zero", {63'd0, bus.out_zero}, 64'd0);
        push(32'h0000_0005, OP_SUB, 1'b1);
        check("sub_carry", {63'd0, bus.out_carry}, 64'd1);
        check("sub_op", {61'd0, bus.out_op}, 64'd4);
        push(32'h0000_0005, OP_XOR, 1'b1);
        check("xor_carry", {63'd0, bus.out_carry}, 64'd0);
        tick();
        check("drain_valid", {63'd0, bus.out_valid}, 64'd0);

        // Backpressure fills main and skid
        bus.out_ready = 1'b0;
        push(32'h1111_1111, OP_AND, 1'b0);
        push(32'h2222_2222, OP_AND, 1'b0);
        check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check("bp_result", {32'd0, bus.out_result}, 64'h1111_1111);
        tick();
        check("bp_hold", {32'd0, bus.out_result}, 64'h1111_1111);
        check("bp_hold_valid", {63'd0, bus.out_valid}, 64'd1);
        bus.out_ready = 1'b1;
        tick();
        check("bp_pop_b", {32'd0, bus.out_result}, 64'h2222_2222);
        check("bp_ready_back", {63'd0, bus.in_ready}, 64'd1);
        tick();
        check("bp_empty", {63'd0, bus.out_valid}, 64'd0);
        check("bp_count", {48'd0, bus.res_count}, 64'd7);

        // Streaming: one result per cycle, in order
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_op     = OP_ADD;
        bus.in_carry  = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.in_result = 32'(i + 32'h100);
            tick();
            check("stream_valid", {63'd0, bus.out_valid}, 64'd1);
            check("stream_data", {32'd0, bus.out_result}, 64'(i + 32'h100));
        end
        bus.in_valid = 1'b0;
        check("stream_count", {48'd0, bus.res_count}, 64'd100);

        // Counter wrap
        do_reset();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        check("wrap_max", {48'd0, bus.res_count}, 64'hFFFF);
        tick();
        bus.in_valid = 1'b0;
        check("wrap_zero", {48'd0, bus.res_count}, 64'd0);
        tick();

        // Asynchronous reset while full
        bus.out_ready = 1'b0;
        push(32'hAAAA_AAAA, OP_AND, 1'b0);
        push(32'hBBBB_BBBB, OP_AND, 1'b0);
        check("ar_full", {63'd0, bus.in_ready}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid_drop", {63'd0, bus.out_valid}, 64'd0);
        check("ar_ready_set", {63'd0, bus.in_ready}, 64'd1);
        tick();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ar_no_stale", {63'd0, bus.out_valid}, 64'd0);
        end
        push(32'h0000_0033, OP_OR, 1'b0);
        check("ar_new_data", {32'd0, bus.out_result}, 64'h0000_0033);
        check("ar_new_count", {48'd0, bus.res_count}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 32-bit combinational ALU datapath (bitwise AND/OR/XOR, add/sub units).
- Captures the selected ALU result and its opcode through a valid/ready handshake.
- Generates zero/negative/carry flags and presents them to the consumer.
- Contains a 2-entry skid buffer so in_ready is registered and the stage sustains one result per cycle without a combinational ready path back into the ALU.

Parameters:
WIDTH, 32, datapath width of ALU result
OPW, 3, opcode width
CNTW, 16, width of accepted-result counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  ALU result valid
in_ready  output  1  stage can accept a result this cycle
in_result  input  WIDTH  ALU result (e.g. bitwise AND output S)
in_op  input  OPW  opcode that produced in_result
in_carry  input  1  carry/borrow out from adder path
out_valid  output  1  registered result available
out_ready  input  1  consumer accepts result
out_result  output  WIDTH  registered result
out_op  output  OPW  registered opcode
out_zero  output  1  result equals 0
out_neg  output  1  result MSB
out_carry  output  1  carry, qualified by opcode
res_count  output  CNTW  number of accepted inputs, modulo 2^CNTW

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While rst_n=0: all state cleared; out_valid=0; out_result=0; out_op=0; all flags 0; res_count=0; state EMPTY; in_ready=1. No transfer completes while in reset.
  - Reset asserted mid-operation discards both buffered entries immediately.
- Transfers:
  - Push = in_valid & in_ready at a rising edge.
  - Pop = out_valid & out_ready at a rising edge.
- Latency: a result pushed at edge N appears on out_* with out_valid=1 after edge N (visible in cycle N+1).
- in_ready is a register: in_ready = (state != FULL). in_valid is never gated combinationally into in_ready.
- FSM states: EMPTY (0 entries), ONE (main reg valid), FULL (main + skid valid).
  - EMPTY: push -> ONE, main <= input.
  - ONE: push & !pop -> FULL, skid <= input. !push & pop -> EMPTY. push & pop -> ONE, main <= input. Neither -> ONE, hold.
  - FULL: pop -> ONE, main <= skid. No push is possible because in_ready=0. !pop -> FULL, hold.
- Ordering: strict FIFO; no result is ever dropped or duplicated.
- Stability: while out_valid=1 and out_ready=0, all out_* are held bit-stable.
- Flags are computed from the input at capture and stored alongside the data in both main and skid:
  - zero = (in_result == 0).
  - neg = in_result[WIDTH-1].
  - carry = in_carry when in_op is OP_ADD or OP_SUB, else 0.
- res_count increments by 1 on every push and wraps from 2^CNTW-1 to 0.
- The upstream ALU uses #1 gate delays. The clock period must exceed the worst-case ALU settle time, and the bench drives operands so that in_result is settled before each edge. The stage itself carries no # delays.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams: OP_AND=0, OP_OR=1, OP_XOR=2, OP_ADD=3, OP_SUB=4, OP_NOT=5;
  - WIDTH default;
  - FSM state encoding: EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
- One natural sub-module, alu_flag_gen: combinational zero/neg/carry generation from result, opcode and carry. It is instantiated once, on the input side.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, res_count=0, in_ready=1. Release; first push of 0x0000_00FF (OP_AND) -> out_result=0x0000_00FF, zero=0, neg=0 one cycle later.
- Flags: push 0x0000_0000 (OP_AND) -> zero=1. Push 0x8000_0001 (OP_OR) -> neg=1. Push with in_carry=1 and OP_SUB -> carry=1. Push with in_carry=1 and OP_XOR -> carry=0.
- Backpressure: out_ready=0, push A=0x1111_1111 then B=0x2222_2222 -> state FULL, in_ready=0, out_result holds 0x1111_1111. Raise out_ready -> pops A then B in order; in_ready returns to 1 one cycle after the first pop.
- Streaming: out_ready=1, in_valid=1 for 100 cycles with incrementing data -> 100 outputs, in order, no bubbles after the first; res_count=100.
- Wrap: preload 65535 pushes (CNTW=16) then one more -> res_count=0.
- Async reset mid-stream: assert rst_n=0 between edges while FULL -> out_valid drops to 0 immediately. After release, stale A/B never appear on the output.
